// File: rtl/mac_feeder.sv
// mac_feeder: sequences one accumulate-and-scale MAC through a run.
// Clears the MAC, streams len operand pairs into it over a valid/ready
// handshake, waits one cycle for the registered accumulator to settle,
// then captures the accumulator into result and pulses done.
module mac_feeder #(
    parameter int LEN_W  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_active,
    output logic              mac_clear,
    output logic [DATA_W-1:0] mac_val1,
    output logic [DATA_W-1:0] mac_val2,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_next;
    logic              capture;

    // Operands pass straight through; the MAC only uses them while active.
    assign mac_val1 = in_a;
    assign mac_val2 = in_b;
    assign busy     = (state != S_IDLE);

    // State and remaining-pair counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Result capture at the end of WAIT; done is high for the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                result <= mac_acc;
            end
        end
    end

    // Next-state, counter update and MAC/handshake control decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        mac_active = 1'b0;
        mac_clear  = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_next   = len;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clear  = 1'b1;
                state_next = (cnt == '0) ? S_WAIT : S_RUN;
            end
            S_RUN: begin
                in_ready   = 1'b1;
                mac_active = in_valid;
                if (in_valid) begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                capture    = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: self-checking bench for mac_feeder with a behavioural
// accumulate-and-scale MAC attached and a result scoreboard.
module tb_mac_feeder;

    localparam int LEN_W  = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              mac_active;
    logic              mac_clear;
    logic [DATA_W-1:0] mac_val1;
    logic [DATA_W-1:0] mac_val2;
    logic [ACC_W-1:0]  mac_acc;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;

    always #5 clk = ~clk;

    mac_feeder #(
        .LEN_W (LEN_W),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_active(mac_active),
        .mac_clear (mac_clear),
        .mac_val1  (mac_val1),
        .mac_val2  (mac_val2),
        .mac_acc   (mac_acc),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Downstream MAC: registered accumulator, not reset by rst, starts dirty.
    logic [31:0] m_acc = 32'h0BAD_F00D;
    logic [15:0] prod;
    assign prod    = 16'(mac_val1) * 16'(mac_val2);
    assign mac_acc = m_acc;
    always_ff @(posedge clk) begin
        if (mac_clear)       m_acc <= '0;
        else if (mac_active) m_acc <= m_acc + {24'b0, prod[15:8]};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge counter and per-cycle event counters, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_act = 0, n_clr = 0, n_rdy = 0, n_hs = 0, n_done = 0, n_both = 0;
    int done_cyc = 0;
    logic [31:0] sb[$];

    always @(negedge clk) begin
        if (mac_active) n_act++;
        if (mac_clear) n_clr++;
        if (in_ready) n_rdy++;
        if (in_ready && in_valid) n_hs++;
        if (mac_active && mac_clear) n_both++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else check("result", result, sb.pop_front());
        end
    end

    logic [7:0]  pa[8];
    logic [7:0]  pb[8];
    int          s_act, s_clr, s_rdy, s_hs, s_done, p0;
    logic [31:0] prev_res;
    logic [31:0] last_exp;

    task automatic begin_run(input int n);
        logic [31:0] e;
        logic [15:0] p;
        e = '0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            p = 16'(pa[i]) * 16'(pb[i]);
            e = e + {24'b0, p[15:8]};
        end
        sb.push_back(e);
        last_exp = e;
        s_act = n_act; s_clr = n_clr; s_rdy = n_rdy; s_hs = n_hs; s_done = n_done;
        p0 = cyc;
        prev_res = result;
        start    = 1'b1;
        len      = LEN_W'(n);
        in_valid = (n > 0);
        in_a     = pa[0];
        in_b     = pb[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = 8'hAA;
    endtask

    task automatic feed(input int n, input int stall, input bit poke, input int abort_after);
        bit got;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (stall > 0) begin
                    in_valid = 1'b0;
                    repeat (stall) @(posedge clk);
                    #1;
                end
                in_valid = 1'b1;
                in_a     = pa[i];
                in_b     = pb[i];
            end
            got = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) check("ready_timeout", 32'd0, 32'd1);
            if (poke && i == 1) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (abort_after == i + 1) return;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (n_done > s_done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic run_full(input int n, input int stall, input bit poke);
        int extra;
        extra = (n > 0) ? stall * (n - 1) : 0;
        begin_run(n);
        feed(n, stall, poke, 0);
        if (n > 0) check("result_held_in_wait", result, prev_res);
        wait_done();
        check("done_cycle", 32'(done_cyc - p0), 32'(n + 3 + extra));
        check("clear_pulses", 32'(n_clr - s_clr), 32'd1);
        check("active_cycles", 32'(n_act - s_act), 32'(n));
        check("handshakes", 32'(n_hs - s_hs), 32'(n));
        check("ready_cycles", 32'(n_rdy - s_rdy), 32'(n + extra));
        @(negedge clk);
        #1;
        check("busy_after", 32'(busy), 32'd0);
        check("done_width", 32'(done), 32'd0);
        check("done_count", 32'(n_done - s_done), 32'd1);
        check("result_hold", result, last_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_active", 32'(mac_active), 32'd0);
        check("rst_clear", 32'(mac_clear), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // len=4, (16,16) x4, no stalls -> 4, done in cycle 7
        for (int i = 0; i < 4; i++) begin pa[i] = 8'd16; pb[i] = 8'd16; end
        run_full(4, 0, 1'b0);

        // len=2, (255,255) x2 -> 508
        pa[0] = 8'd255; pb[0] = 8'd255; pa[1] = 8'd255; pb[1] = 8'd255;
        run_full(2, 0, 1'b0);

        // len=3 with 2-cycle stalls between pairs -> 6, done 4 cycles later
        pa[0] = 8'd32; pb[0] = 8'd32; pa[1] = 8'd8; pb[1] = 8'd64; pa[2] = 8'd255; pb[2] = 8'd1;
        run_full(3, 2, 1'b0);

        // len=0 -> CLEAR, WAIT, DONE, result 0, no ready
        run_full(0, 0, 1'b0);

        // start re-pulsed during RUN is ignored -> 1+254+4
        pa[0] = 8'd16; pb[0] = 8'd16; pa[1] = 8'd255; pb[1] = 8'd255; pa[2] = 8'd32; pb[2] = 8'd32;
        run_full(3, 1, 1'b1);

        // async reset after 2 of 5 pairs: abandon run, no done
        for (int i = 0; i < 5; i++) begin pa[i] = 8'd16; pb[i] = 8'd16; end
        begin_run(5);
        feed(5, 0, 1'b0, 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_active", 32'(mac_active), 32'd0);
        check("arst_clear", 32'(mac_clear), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        void'(sb.pop_back());
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("arst_no_done", 32'(n_done - s_done), 32'd0);

        // fresh len=1 (16,16) -> 1, proves the MAC is cleared
        pa[0] = 8'd16; pb[0] = 8'd16;
        run_full(1, 0, 1'b0);

        check("never_clear_and_active", 32'(n_both), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
